poly_tone_mixer: RTL
====================

Name: poly_tone_mixer

Overview:
Polyphonic square-wave synthesiser that replaces the single shared divider and tone generator in the top level. It has NUM_CH independent voices, each with its own half-period divider and phase. The voices are summed with saturation into one signed sample. The sample is decimated to a programmable audio rate and delivered to the audio codec output FIFO through a valid/allowed handshake with overrun accounting. It sits between the input_handler channels (key_on) and the codec's left/right channel inputs.

Parameters:
NUM_CH, 6, number of voices
DIV_W, 19, width of each per-voice half-period field and counter
SAMPLE_W, 32, signed output sample width
AMP, 110000000, per-voice amplitude magnitude; must fit in signed SAMPLE_W
SAMPLE_DIV, 1042, clock cycles per output sample (minimum 1)

Ports:
clock  in  1  system clock
resetn  in  1  asynchronous active-low reset
key_on  in  NUM_CH  per-voice gate, bit i = voice i
half_period  in  NUM_CH*DIV_W  voice i half-period in [i*DIV_W +: DIV_W]; 0 = voice muted
audio_out_allowed  in  1  codec FIFO has room
sample_out  out  SAMPLE_W  signed sample offered to codec (both channels)
write_audio_out  out  1  transfer strobe; sample_out consumed this cycle
voice_count  out  $clog2(NUM_CH+1)  number of sounding voices
overrun_count  out  8  samples overwritten before transfer, saturating

Behaviour:
- Reset (async, resetn=0): key_q, all counters, phases, mix_q, tick counter, sample_out, pending, overrun_count and voice_count go to 0. write_audio_out is 0.
- Input stage: key_q <= key_on every cycle. half_period is used unregistered.
- Voice i sounds when key_q[i]=1 and hp_i!=0.
- Voice i not sounding: cnt_i <= 0, phase_i <= 0. Every note-on therefore starts at phase 0.
- Voice i sounding, cnt_i >= hp_i: cnt_i <= 0, phase_i <= ~phase_i. Otherwise cnt_i <= cnt_i+1.
- Resulting period is 2*(hp_i+1) cycles. A hp change takes effect immediately; if the counter is already above the new value, the voice toggles next cycle.
- Voice level: sounding and phase_i=0 gives +AMP; sounding and phase_i=1 gives -AMP; not sounding gives 0.
- Mix: signed sum in a SAMPLE_W+$clog2(NUM_CH)+1 accumulator, saturated to [-2^(SAMPLE_W-1), 2^(SAMPLE_W-1)-1], registered into mix_q.
- Latency: key_on high before edge k puts key_q=1 at edge k and the voice in mix_q at edge k+1.
- voice_count is registered alongside mix_q and counts sounding voices.
- Tick counter: counts 0..SAMPLE_DIV-1 and wraps. tick=1 on the cycle the count equals SAMPLE_DIV-1.
- Handshake: write_audio_out = pending & audio_out_allowed (combinational). When it is 1, the current sample_out is transferred.
- tick only: sample_out <= mix_q. If pending=1, overrun_count++ (saturates at 255). pending <= 1.
- write only: pending <= 0.
- tick and write in the same cycle: the old sample_out is transferred, the new mix_q is loaded, pending stays 1, and there is no overrun.
- Neither tick nor write: all state holds. sample_out is stable while pending=1.
- Reset mid-transfer: the pending sample is dropped. The first sample after reset release comes SAMPLE_DIV cycles later.
- SAMPLE_DIV=1: tick every cycle. With audio_out_allowed=1 there is one write per cycle carrying mix_q from the previous cycle.

Test Plan:
- Async reset: assert resetn=0 between clock edges while pending=1 -> sample_out=0, write_audio_out=0, overrun_count=0 immediately; no write after release until the first tick.
- Single voice: AMP=1000, SAMPLE_DIV=1, hp[0]=4, key_on=6'b000001, allowed=1 -> written samples after latency: 5x +1000, 5x -1000, repeating (period 10); voice_count=1.
- Note-on phase restart: key_on[0] dropped mid -1000 half-cycle and raised 3 cycles later -> samples 0 for the off period, then restart at +1000 for a full 5 samples.
- Saturation: SAMPLE_W=16, AMP=20000, hp[0]=hp[1]=9, both keys raised in the same cycle -> samples 32767 for 10, -32768 for 10; no wrap.
- Mute and mix: hp=(3,0,7), key_on=3'b111, AMP=100 -> voice 1 contributes 0, voice_count=2; samples sequence over {+200, 0, -200} matching the independent periods 8 and 16.
- Backpressure: SAMPLE_DIV=4, allowed=0 across 3 ticks -> overrun_count=2, sample_out = value from the third tick. Raise allowed -> exactly one write pulse. Also force tick and write in the same cycle -> no overrun increment, pending stays 1.

Source files
------------

// File: rtl/poly_tone_mixer.sv
// Polyphonic square-wave synthesiser: per-voice half-period dividers, saturating mix,
// and a decimated sample handed to the codec FIFO with overrun accounting.
module poly_tone_mixer #(
    parameter int NUM_CH     = 6,
    parameter int DIV_W      = 19,
    parameter int SAMPLE_W   = 32,
    parameter int AMP        = 110000000,
    parameter int SAMPLE_DIV = 1042
) (
    input  logic                          clock,
    input  logic                          resetn,
    input  logic [NUM_CH-1:0]             key_on,
    input  logic [NUM_CH*DIV_W-1:0]       half_period,
    input  logic                          audio_out_allowed,
    output logic signed [SAMPLE_W-1:0]    sample_out,
    output logic                          write_audio_out,
    output logic [$clog2(NUM_CH+1)-1:0]   voice_count,
    output logic [7:0]                    overrun_count
);

    localparam int VC_W   = $clog2(NUM_CH + 1);
    localparam int ACC_W  = SAMPLE_W + $clog2(NUM_CH) + 1;
    localparam int TICK_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;

    localparam logic signed [ACC_W-1:0] AMP_ACC = ACC_W'(AMP);
    localparam logic signed [ACC_W-1:0] SAT_MAX =
        {{(ACC_W-SAMPLE_W+1){1'b0}}, {(SAMPLE_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN =
        {{(ACC_W-SAMPLE_W+1){1'b1}}, {(SAMPLE_W-1){1'b0}}};
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(SAMPLE_DIV - 1);

    logic [NUM_CH-1:0]          r_key_q;
    logic signed [SAMPLE_W-1:0] r_mix_q;
    logic [VC_W-1:0]            r_voice_count;
    logic [TICK_W-1:0]          r_tick_cnt;
    logic signed [SAMPLE_W-1:0] r_sample_out;
    logic                       r_pending;
    logic [7:0]                 r_overrun;

    logic [NUM_CH-1:0]          w_sound;
    logic [NUM_CH-1:0]          w_phase;
    logic signed [ACC_W-1:0]    w_acc;
    logic signed [SAMPLE_W-1:0] w_mix;
    logic [VC_W-1:0]            w_vc;
    logic                       w_tick;
    logic                       w_write;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_key_q <= '0;
        end else begin
            r_key_q <= key_on;
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_voice
        logic [DIV_W-1:0] w_hp;
        logic [DIV_W-1:0] r_cnt;
        logic             r_phase;

        assign w_hp       = half_period[g*DIV_W +: DIV_W];
        assign w_sound[g] = r_key_q[g] && (w_hp != '0);
        assign w_phase[g] = r_phase;

        // A silent voice is parked at phase 0 so every note-on starts high.
        always_ff @(posedge clock or negedge resetn) begin
            if (!resetn) begin
                r_cnt   <= '0;
                r_phase <= 1'b0;
            end else if (!w_sound[g]) begin
                r_cnt   <= '0;
                r_phase <= 1'b0;
            end else if (r_cnt >= w_hp) begin
                r_cnt   <= '0;
                r_phase <= ~r_phase;
            end else begin
                r_cnt   <= r_cnt + DIV_W'(1);
            end
        end
    end

    // NOTE: every combinational output gets a default before the loop so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_acc = '0;
        w_vc  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (w_sound[i]) begin
                w_acc = w_phase[i] ? (w_acc - AMP_ACC) : (w_acc + AMP_ACC);
                w_vc  = w_vc + VC_W'(1);
            end
        end
        if (w_acc > SAT_MAX) begin
            w_mix = SAT_MAX[SAMPLE_W-1:0];
        end else if (w_acc < SAT_MIN) begin
            w_mix = SAT_MIN[SAMPLE_W-1:0];
        end else begin
            w_mix = w_acc[SAMPLE_W-1:0];
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_mix_q       <= '0;
            r_voice_count <= '0;
        end else begin
            r_mix_q       <= w_mix;
            r_voice_count <= w_vc;
        end
    end

    assign w_tick  = (r_tick_cnt == TICK_LAST);
    assign w_write = r_pending & audio_out_allowed;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_tick_cnt <= '0;
        end else if (w_tick) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + TICK_W'(1);
        end
    end

    // A tick that lands on a transfer cycle replaces an already-consumed sample,
    // so only an untransferred pending sample counts as overrun.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_sample_out <= '0;
            r_pending    <= 1'b0;
            r_overrun    <= '0;
        end else if (w_tick) begin
            r_sample_out <= r_mix_q;
            r_pending    <= 1'b1;
            if (r_pending && !w_write && (r_overrun != 8'hFF)) begin
                r_overrun <= r_overrun + 8'd1;
            end
        end else if (w_write) begin
            r_pending <= 1'b0;
        end
    end

    assign sample_out      = r_sample_out;
    assign write_audio_out = w_write;
    assign voice_count     = r_voice_count;
    assign overrun_count   = r_overrun;

endmodule
